pn_controller: RTL

//  Physical-neuron controller that configures and sequences one soma instance.
//  - Loads the neuron constant word (V_th/V_leak/refr_time/axon_delay).
//  - Buffers timestamped synapse events and converts timestamps to spike intervals.
//  - Dispatches {interval, weight} to the soma, stalling while soma signals wait.
//  - Drives the soma's en/kill and counts output spikes.

---
 rtl/pn_pkg.sv | 35 +++
 rtl/pn_controller_if.sv | 35 +++
 rtl/pn_event_fifo.sv | 63 ++++++
 rtl/pn_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared types and constants for the physical-neuron controller.
package pn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_READY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_KILL   = 3'd5
    } state_t;

    localparam int unsigned CFG_W     = 32;
    localparam int unsigned VTH_LSB   = 24;
    localparam int unsigned VLEAK_LSB = 16;
    localparam int unsigned REFR_LSB  = 8;
    localparam int unsigned AXON_LSB  = 0;

    // Interval reported for the first dispatch after start (truncated to TS_W)
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Assemble a neuron constant word from its four byte fields
    function automatic logic [CFG_W-1:0] pack_cfg(
        input logic [7:0] v_th,
        input logic [7:0] v_leak,
        input logic [7:0] refr_time,
        input logic [7:0] axon_delay
    );
        return (CFG_W'(v_th)       << VTH_LSB)   |
               (CFG_W'(v_leak)     << VLEAK_LSB) |
               (CFG_W'(refr_time)  << REFR_LSB)  |
               (CFG_W'(axon_delay) << AXON_LSB);
    endfunction

endpackage

// File: rtl/pn_controller_if.sv
// Config, event and soma-side signal bundle of the neuron controller.
interface pn_controller_if #(
    parameter int unsigned TS_W = 16,
    parameter int unsigned WT_W = 16
);
    logic             cfg_valid;
    logic [31:0]      cfg_data;
    logic             cfg_ready;
    logic             start;
    logic             stop;
    logic             ev_valid;
    logic             ev_ready;
    logic [TS_W-1:0]  ev_time;
    logic [WT_W-1:0]  ev_weight;
    logic             soma_wait;
    logic [15:0]      soma_spike;
    logic             pn_en;
    logic             pn_kill;
    logic [31:0]      w_data;
    logic [WT_W-1:0]  weight;
    logic             busy;
    logic [15:0]      spike_cnt;

    modport slave (
        input  cfg_valid, cfg_data, start, stop, ev_valid, ev_time, ev_weight,
               soma_wait, soma_spike,
        output cfg_ready, ev_ready, pn_en, pn_kill, w_data, weight, busy, spike_cnt
    );

    modport master (
        output cfg_valid, cfg_data, start, stop, ev_valid, ev_time, ev_weight,
               soma_wait, soma_spike,
        input  cfg_ready, ev_ready, pn_en, pn_kill, w_data, weight, busy, spike_cnt
    );
endinterface

// File: rtl/pn_event_fifo.sv
// Small synchronous FIFO buffering {timestamp, weight} synapse events.
module pn_event_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Status decode, gated handshakes and next pointer/count values
    always_comb begin
        full     = (cnt_q == LW'(DEPTH));
        empty    = (cnt_q == '0);
        level    = cnt_q;
        rdata    = mem_q[rd_ptr_q];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + LW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful below the level
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pn_controller.sv
// Sequences one soma: configuration load, event dispatch as intervals, kill and spike counting.
module pn_controller
    import pn_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned WT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    pn_controller_if.slave bus
);
    localparam int unsigned EV_W  = TS_W + WT_W;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = 16;

    state_t            state_q, state_d;
    logic [CFG_W-1:0]  cfg_reg_q, cfg_reg_d;
    logic [TS_W-1:0]   last_ts_q, last_ts_d;
    logic              first_q, first_d;
    logic              pn_en_q, pn_en_d;
    logic              pn_kill_q, pn_kill_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [WT_W-1:0]   weight_q, weight_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  spike_cnt_q, spike_cnt_d;

    logic              cfg_ready_c, ev_ready_c, cfg_hs_c, ev_hs_c;
    logic              active_c, dispatch_c;
    logic [TS_W-1:0]   interval_c;
    logic [TS_W-1:0]   pop_ts_c;
    logic [WT_W-1:0]   pop_wt_c;
    logic [EV_W-1:0]   fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    pn_event_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_hs_c),
        .pop   (dispatch_c),
        .wdata ({bus.ev_time, bus.ev_weight}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign pop_ts_c = fifo_rdata[EV_W-1 -: TS_W];
    assign pop_wt_c = fifo_rdata[WT_W-1:0];

    // Ready decode from state and FIFO occupancy; dispatch qualification
    always_comb begin
        cfg_ready_c = (state_q == ST_IDLE) || (state_q == ST_READY);
        ev_ready_c  = (state_q == ST_RUN) && !fifo_full;
        cfg_hs_c    = bus.cfg_valid && cfg_ready_c;
        ev_hs_c     = bus.ev_valid && ev_ready_c;
        active_c    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        dispatch_c  = active_c && !fifo_empty && !bus.soma_wait;
    end

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.ev_ready  = ev_ready_c;
    assign bus.pn_en     = pn_en_q;
    assign bus.pn_kill   = pn_kill_q;
    assign bus.w_data    = w_data_q;
    assign bus.weight    = weight_q;
    assign bus.busy      = busy_q;
    assign bus.spike_cnt = spike_cnt_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cfg_reg_q   <= '0;
            last_ts_q   <= '0;
            first_q     <= 1'b0;
            pn_en_q     <= 1'b0;
            pn_kill_q   <= 1'b0;
            w_data_q    <= '0;
            weight_q    <= '0;
            busy_q      <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_reg_q   <= cfg_reg_d;
            last_ts_q   <= last_ts_d;
            first_q     <= first_d;
            pn_en_q     <= pn_en_d;
            pn_kill_q   <= pn_kill_d;
            w_data_q    <= w_data_d;
            weight_q    <= weight_d;
            busy_q      <= busy_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    // Next-state logic; stop takes priority over start, start over a new config
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_hs_c) state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                if (bus.stop) begin
                    state_d = ST_KILL;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end else if (cfg_hs_c) begin
                    state_d = ST_CONFIG;
                end
            end
            ST_RUN: begin
                if (bus.stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((fifo_level == '0) && !bus.soma_wait) state_d = ST_KILL;
            end
            ST_KILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs aligned with the state being entered
    always_comb begin
        cfg_reg_d   = cfg_reg_q;
        last_ts_d   = last_ts_q;
        first_d     = first_q;
        w_data_d    = w_data_q;
        weight_d    = '0;
        spike_cnt_d = spike_cnt_q;
        pn_en_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        pn_kill_d   = (state_d == ST_KILL);
        busy_d      = (state_d != ST_IDLE);
        interval_c  = first_q ? TS_W'(ALL_ONES) : TS_W'(pop_ts_c - last_ts_q);

        if (cfg_hs_c) begin
            cfg_reg_d = bus.cfg_data;
        end
        if (state_d == ST_CONFIG) begin
            w_data_d = cfg_reg_d;
        end

        if (dispatch_c) begin
            last_ts_d = pop_ts_c;
            first_d   = 1'b0;
            w_data_d  = 32'(interval_c);
            weight_d  = pop_wt_c;
        end

        if ((state_d == ST_RUN) && (state_q == ST_READY)) begin
            first_d     = 1'b1;
            spike_cnt_d = '0;
        end else if (active_c && (bus.soma_spike != '0) && (spike_cnt_q != '1)) begin
            spike_cnt_d = spike_cnt_q + CNT_W'(1);
        end
    end

endmodule
